exec_stage: RTL and testbench

//  Execute stage; consumes the decode->execute pipeline register outputs.

---
 rtl/exec_stage_pkg.sv | 37 +++
 rtl/exec_stage_if.sv | 46 ++++
 rtl/exec_stage_muldiv_unit.sv | 142 ++++++++++++++
 rtl/exec_stage.sv | 73 +++++++
 tb/tb_exec_stage.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared constants and types for the execute stage: datapath
//            width, ALU control codes, RV32M funct3 opcodes, mul/div states.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage
`default_nettype wire

// File: rtl/exec_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_stage_if
// Brief    : Decode->execute inputs and execute->memory/hazard outputs.
//            master drives the pipeline-register side, slave is the stage.
// Revision : 1.0 - initial release
// ============================================================================
interface exec_stage_if;
  import riscv_pkg::*;

  logic [2:0]      ALUControlE_i;
  logic            ALUSrcE_i;
  logic            BranchE_i;
  logic            JumpE_i;
  logic            MulDivE_i;
  logic [2:0]      MulDivOpE_i;
  logic [XLEN-1:0] RD1E_i;
  logic [XLEN-1:0] RD2E_i;
  logic [XLEN-1:0] ImmExtE_i;
  logic [XLEN-1:0] PCE_i;
  logic [1:0]      ForwardAE_i;
  logic [1:0]      ForwardBE_i;
  logic [XLEN-1:0] ALUResultM_i;
  logic [XLEN-1:0] ResultW_i;
  logic [XLEN-1:0] ALUResultE_o;
  logic [XLEN-1:0] WriteDataE_o;
  logic [XLEN-1:0] PCTargetE_o;
  logic            PCSrcE_o;
  logic            StallE_o;

  modport master (
    output ALUControlE_i, ALUSrcE_i, BranchE_i, JumpE_i, MulDivE_i, MulDivOpE_i,
           RD1E_i, RD2E_i, ImmExtE_i, PCE_i, ForwardAE_i, ForwardBE_i,
           ALUResultM_i, ResultW_i,
    input  ALUResultE_o, WriteDataE_o, PCTargetE_o, PCSrcE_o, StallE_o
  );

  modport slave (
    input  ALUControlE_i, ALUSrcE_i, BranchE_i, JumpE_i, MulDivE_i, MulDivOpE_i,
           RD1E_i, RD2E_i, ImmExtE_i, PCE_i, ForwardAE_i, ForwardBE_i,
           ALUResultM_i, ResultW_i,
    output ALUResultE_o, WriteDataE_o, PCTargetE_o, PCSrcE_o, StallE_o
  );

endinterface
`default_nettype wire

// File: rtl/exec_stage_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M unit. One shift-add or restoring shift-subtract
//            step per cycle on operand magnitudes, sign fix-up at the end.
//            Divide-by-zero and signed overflow bypass the iteration.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            i_start,
  input  muldiv_op_e      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int              CW     = $clog2(XLEN);
  localparam logic [CW-1:0]   c_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     r_state, w_state_nxt;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_b_mag;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg_lo;
  logic              r_neg_rem;
  logic              r_special;
  logic [XLEN-1:0]   r_spec_res;

  logic [2:0]        w_op;
  logic              w_a_neg, w_b_neg, w_div0, w_ovf, w_special;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_spec_res;
  logic [XLEN:0]     w_mul_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_sel;

  // Operand decode at start: signedness per funct3, magnitudes, special cases
  always_comb begin
    w_op     = i_op;
    w_a_neg  = i_a[XLEN-1] & (w_op[2] ? ~w_op[0] : (w_op != MD_MULHU));
    w_b_neg  = i_b[XLEN-1] & (w_op[2] ? ~w_op[0] : (w_op == MD_MUL || w_op == MD_MULH));
    w_a_mag  = w_a_neg ? -i_a : i_a;
    w_b_mag  = w_b_neg ? -i_b : i_b;
    w_div0   = w_op[2] & (i_b == '0);
    w_ovf    = w_op[2] & ~w_op[0] & (i_a == c_MIN) & (i_b == '1);
    w_special = w_div0 | w_ovf;
    w_spec_res = '0;
    if (w_div0)     w_spec_res = w_op[1] ? i_a : '1;
    else if (w_ovf) w_spec_res = w_op[1] ? '0 : c_MIN;
  end

  // One iteration step for each algorithm; hi half holds sum/remainder
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b_mag} : '0);
    w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    w_diff    = w_rem_sh - {1'b0, r_b_mag};
    w_div_nxt = w_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                             : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  end

  // Sign correction and result selection from the finished accumulator
  always_comb begin
    w_prod = r_neg_lo  ? -r_acc : r_acc;
    w_quot = r_neg_lo  ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    w_sel  = '0;
    case (r_op)
      MD_MUL:                       w_sel = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_sel = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_sel = w_quot;
      default:                      w_sel = w_rem;
    endcase
  end

  // State and step counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next state: special cases skip straight to DONE
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: begin
        w_count_nxt = '0;
        if (i_start) w_state_nxt = w_special ? DONE : BUSY;
      end
      BUSY: begin
        if (r_count == c_LAST) begin
          w_state_nxt = DONE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on start, iterate while busy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op       <= '0;
      r_b_mag    <= '0;
      r_acc      <= '0;
      r_neg_lo   <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_op       <= w_op;
      r_b_mag    <= w_b_mag;
      r_acc      <= {{XLEN{1'b0}}, w_a_mag};
      r_neg_lo   <= w_a_neg ^ w_b_neg;
      r_neg_rem  <= w_a_neg;
      r_special  <= w_special;
      r_spec_res <= w_spec_res;
    end else if (r_state == BUSY) begin
      r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
    end
  end

  assign o_done   = (r_state == DONE);
  assign o_result = o_done ? (r_special ? r_spec_res : w_sel) : '0;

endmodule
`default_nettype wire

// File: rtl/exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : exec_stage
// Brief    : Execute stage: forwarding muxes, ALU, branch resolution and
//            target adder, plus the iterative mul/div unit that stalls the
//            front of the pipeline until its result is ready.
// Revision : 1.0 - initial release
// ============================================================================
module exec_stage
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  exec_stage_if.slave bus
);

  logic [XLEN-1:0] w_src_a, w_fwd_b, w_src_b, w_alu, w_md_result;
  logic            w_zero, w_md_done;
  muldiv_op_e      w_md_op;

  // Operand forwarding; encoding 11 falls back to the register file value
  always_comb begin
    w_src_a = bus.RD1E_i;
    case (bus.ForwardAE_i)
      2'b01:   w_src_a = bus.ResultW_i;
      2'b10:   w_src_a = bus.ALUResultM_i;
      default: w_src_a = bus.RD1E_i;
    endcase
    w_fwd_b = bus.RD2E_i;
    case (bus.ForwardBE_i)
      2'b01:   w_fwd_b = bus.ResultW_i;
      2'b10:   w_fwd_b = bus.ALUResultM_i;
      default: w_fwd_b = bus.RD2E_i;
    endcase
    w_src_b = bus.ALUSrcE_i ? bus.ImmExtE_i : w_fwd_b;
  end

  // ALU; undefined control codes produce zero
  always_comb begin
    w_alu = '0;
    case (bus.ALUControlE_i)
      ALU_ADD: w_alu = w_src_a + w_src_b;
      ALU_SUB: w_alu = w_src_a - w_src_b;
      ALU_AND: w_alu = w_src_a & w_src_b;
      ALU_OR:  w_alu = w_src_a | w_src_b;
      ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      default: w_alu = '0;
    endcase
    w_zero = (w_alu == '0);
  end

  assign w_md_op = muldiv_op_e'(bus.MulDivOpE_i);

  muldiv_unit u_muldiv (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_start  (bus.MulDivE_i),
    .i_op     (w_md_op),
    .i_a      (w_src_a),
    .i_b      (w_fwd_b),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  // The stall drops in the DONE cycle so the pipeline advances at its end
  assign bus.StallE_o     = rst_ni & bus.MulDivE_i & ~w_md_done;
  assign bus.ALUResultE_o = bus.MulDivE_i ? w_md_result : w_alu;
  assign bus.WriteDataE_o = w_fwd_b;
  assign bus.PCTargetE_o  = bus.PCE_i + bus.ImmExtE_i;
  assign bus.PCSrcE_o     = ~bus.MulDivE_i & (bus.JumpE_i | (bus.BranchE_i & w_zero));

endmodule
`default_nettype wire

// File: tb/tb_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_stage
// Brief    : Self-checking bench for exec_stage with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_stage;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  exec_stage_if bus ();

  exec_stage dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } md_exp_t;

  typedef struct {
    logic [2:0]  ctrl;
    logic        src;
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, imm, m, w;
    logic [31:0] exp_res, exp_wd;
  } alu_vec_t;

  md_exp_t     md_q[$];
  logic [31:0] alu_q[$];

  localparam logic [31:0] c_MIN = 32'h8000_0000;

  // Independent reference for RV32M built on 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == c_MIN && b == 32'hFFFF_FFFF) return c_MIN;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == c_MIN && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == c_MIN && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic alu_vec_t mk_alu(input logic [2:0] ctrl, input logic src, input logic [1:0] fa,
                                      input logic [1:0] fb, input logic [31:0] rd1, input logic [31:0] rd2,
                                      input logic [31:0] imm, input logic [31:0] m, input logic [31:0] w,
                                      input logic [31:0] er, input logic [31:0] ewd);
    alu_vec_t v;
    v.ctrl = ctrl; v.src = src; v.fa = fa; v.fb = fb; v.rd1 = rd1; v.rd2 = rd2;
    v.imm = imm; v.m = m; v.w = w; v.exp_res = er; v.exp_wd = ewd;
    return v;
  endfunction

  task automatic expect_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_exp_t e;
    e.res = ref_md(op, a, b);
    e.lat = exp_lat(op, a, b);
    md_q.push_back(e);
  endtask

  // Issue one M instruction and wait for the non-stalled cycle; forward
  // sources and opcode are scrambled once the operands have been latched.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int stalls, output logic [31:0] res, output bit tmo);
    bus.MulDivE_i   = 1'b1;
    bus.MulDivOpE_i = op;
    bus.RD1E_i      = a;
    bus.RD2E_i      = b;
    bus.ForwardAE_i = 2'b00;
    bus.ForwardBE_i = 2'b00;
    bus.ALUSrcE_i   = 1'b1;
    bus.ImmExtE_i   = $urandom;
    stalls = 0;
    res    = '0;
    tmo    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.StallE_o === 1'b1) stalls++;
      else begin
        res = bus.ALUResultE_o;
        tmo = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!tmo) break;
      if (i == 0) begin
        bus.RD1E_i       = $urandom;
        bus.RD2E_i       = $urandom;
        bus.ALUResultM_i = $urandom;
        bus.ResultW_i    = $urandom;
        bus.ForwardAE_i  = 2'($urandom);
        bus.MulDivOpE_i  = 3'($urandom);
      end
    end
    if (!hold) bus.MulDivE_i = 1'b0;
  endtask

  task automatic test_reset;
    bus.MulDivE_i = 1'b1;
    #2;
    n_tests++;
    if (bus.StallE_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall got=%b want=0", bus.StallE_o);
    end
    bus.MulDivE_i = 1'b0;
    bus.ALUControlE_i = 3'b000;
    bus.RD1E_i = 32'd1;
    bus.RD2E_i = 32'd2;
    #1;
    n_tests++;
    if (bus.ALUResultE_o !== 32'd3) begin
      n_fail++;
      $display("FAIL reset_alu got=%h want=%h", bus.ALUResultE_o, 32'd3);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_forward;
    alu_vec_t tv[$];
    logic [31:0] e;
    tv.push_back(mk_alu(3'b000, 0, 2'b10, 2'b00, 32'd100, 32'd7, 0, 32'd5, 0, 32'd12, 32'd7));
    tv.push_back(mk_alu(3'b001, 0, 2'b00, 2'b01, 32'd20, 32'd99, 0, 0, 32'd8, 32'd12, 32'd8));
    tv.push_back(mk_alu(3'b010, 0, 2'b00, 2'b00, 32'hF0F0, 32'hFF00, 0, 0, 0, 32'hF000, 32'hFF00));
    tv.push_back(mk_alu(3'b011, 0, 2'b00, 2'b00, 32'hF0F0, 32'hFF00, 0, 0, 0, 32'hFFF0, 32'hFF00));
    tv.push_back(mk_alu(3'b101, 0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 32'd1, 32'd1));
    tv.push_back(mk_alu(3'b101, 0, 2'b00, 2'b00, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 32'd0, 32'hFFFF_FFFF));
    tv.push_back(mk_alu(3'b111, 0, 2'b00, 2'b00, 32'd5, 32'd6, 0, 0, 0, 32'd0, 32'd6));
    tv.push_back(mk_alu(3'b000, 1, 2'b00, 2'b00, 32'd3, 32'd77, 32'h10, 0, 0, 32'h13, 32'd77));
    tv.push_back(mk_alu(3'b000, 0, 2'b11, 2'b00, 32'd4, 32'd1, 0, 32'd99, 32'd98, 32'd5, 32'd1));
    tv.push_back(mk_alu(3'b001, 0, 2'b00, 2'b10, 32'd50, 32'd1, 0, 32'd8, 0, 32'd42, 32'd8));
    foreach (tv[i]) begin
      bus.MulDivE_i = 1'b0;
      bus.ALUControlE_i = tv[i].ctrl;
      bus.ALUSrcE_i = tv[i].src;
      bus.ForwardAE_i = tv[i].fa;
      bus.ForwardBE_i = tv[i].fb;
      bus.RD1E_i = tv[i].rd1;
      bus.RD2E_i = tv[i].rd2;
      bus.ImmExtE_i = tv[i].imm;
      bus.ALUResultM_i = tv[i].m;
      bus.ResultW_i = tv[i].w;
      alu_q.push_back(tv[i].exp_res);
      #1;
      e = alu_q.pop_front();
      n_tests++;
      if (bus.ALUResultE_o !== e) begin
        n_fail++;
        $display("FAIL alu_result[%0d] got=%h want=%h", i, bus.ALUResultE_o, e);
      end
      n_tests++;
      if (bus.WriteDataE_o !== tv[i].exp_wd) begin
        n_fail++;
        $display("FAIL alu_writedata[%0d] got=%h want=%h", i, bus.WriteDataE_o, tv[i].exp_wd);
      end
      n_tests++;
      if (bus.StallE_o !== 1'b0) begin
        n_fail++;
        $display("FAIL alu_stall[%0d] got=%b want=0", i, bus.StallE_o);
      end
    end
    bus.ALUSrcE_i = 1'b0;
    bus.ForwardAE_i = 2'b00;
    bus.ForwardBE_i = 2'b00;
  endtask

  task automatic test_branch;
    // rd1, rd2, branch, jump, muldiv, pc, imm, exp_pcsrc, exp_target
    logic [31:0] r1[6] , r2[6], pc[6], im[6], tg[6];
    logic        br[6], jp[6], md[6], ps[6];
    r1 = '{9, 9, 1, 1, 3, 9};
    r2 = '{9, 8, 2, 2, 3, 9};
    br = '{1, 1, 0, 0, 1, 0};
    jp = '{0, 0, 1, 0, 0, 1};
    md = '{0, 0, 0, 0, 0, 1};
    ps = '{1, 0, 1, 0, 1, 0};
    pc = '{32'h100, 32'h100, 32'h200, 32'h300, 32'hFFFF_FFF0, 32'h400};
    im = '{32'h20, 32'h20, 32'hFFFF_FFFC, 32'h8, 32'h20, 32'h4};
    tg = '{32'h120, 32'h120, 32'h1FC, 32'h308, 32'h10, 32'h404};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      bus.ALUControlE_i = 3'b001;
      bus.ALUSrcE_i = 1'b0;
      bus.RD1E_i = r1[i];
      bus.RD2E_i = r2[i];
      bus.BranchE_i = br[i];
      bus.JumpE_i = jp[i];
      bus.MulDivE_i = md[i];
      bus.PCE_i = pc[i];
      bus.ImmExtE_i = im[i];
      #1;
      n_tests++;
      if (bus.PCSrcE_o !== ps[i]) begin
        n_fail++;
        $display("FAIL branch_pcsrc[%0d] got=%b want=%b", i, bus.PCSrcE_o, ps[i]);
      end
      n_tests++;
      if (bus.PCTargetE_o !== tg[i]) begin
        n_fail++;
        $display("FAIL branch_target[%0d] got=%h want=%h", i, bus.PCTargetE_o, tg[i]);
      end
      bus.MulDivE_i = 1'b0;
    end
    bus.BranchE_i = 1'b0;
    bus.JumpE_i = 1'b0;
  endtask

  task automatic test_mul;
    logic [2:0] ops[$];
    logic [31:0] as[$], bs[$], r;
    md_exp_t e;
    int st;
    bit tmo;
    ops = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3};
    as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_MIN,
            $urandom, $urandom, $urandom, $urandom};
    bs  = '{32'd2, 32'd2, 32'd2, 32'd2, c_MIN, $urandom, $urandom, $urandom, $urandom};
    foreach (ops[i]) begin
      expect_md(ops[i], as[i], bs[i]);
      run_md(ops[i], as[i], bs[i], 1'b0, st, r, tmo);
      e = md_q.pop_front();
      n_tests++;
      if (tmo) begin n_fail++; $display("FAIL mul_timeout[%0d] got=no_done want=done", i); end
      n_tests++;
      if (r !== e.res) begin
        n_fail++;
        $display("FAIL mul_result[%0d] op=%0d a=%h b=%h got=%h want=%h", i, ops[i], as[i], bs[i], r, e.res);
      end
      n_tests++;
      if (st !== e.lat) begin n_fail++; $display("FAIL mul_stall[%0d] got=%0d want=%0d", i, st, e.lat); end
    end
  endtask

  task automatic test_div;
    logic [2:0] ops[$];
    logic [31:0] as[$], bs[$], r;
    md_exp_t e;
    int st;
    bit tmo;
    ops = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7};
    as  = '{-32'sd7, -32'sd7, 32'h1234, 32'h1234, 32'h55, 32'h55, 32'd100, 32'd7, 32'd7,
            $urandom, $urandom, $urandom, $urandom};
    bs  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7, -32'sd2, -32'sd2,
            $urandom, $urandom_range(1, 1000), $urandom_range(1, 1000), $urandom};
    foreach (ops[i]) begin
      expect_md(ops[i], as[i], bs[i]);
      run_md(ops[i], as[i], bs[i], 1'b0, st, r, tmo);
      e = md_q.pop_front();
      n_tests++;
      if (tmo) begin n_fail++; $display("FAIL div_timeout[%0d] got=no_done want=done", i); end
      n_tests++;
      if (r !== e.res) begin
        n_fail++;
        $display("FAIL div_result[%0d] op=%0d a=%h b=%h got=%h want=%h", i, ops[i], as[i], bs[i], r, e.res);
      end
      n_tests++;
      if (st !== e.lat) begin n_fail++; $display("FAIL div_stall[%0d] got=%0d want=%0d", i, st, e.lat); end
    end
  endtask

  task automatic test_overflow;
    logic [2:0] ops[4];
    logic [31:0] r;
    md_exp_t e;
    int st;
    bit tmo;
    ops = '{3'd4, 3'd6, 3'd5, 3'd7};
    foreach (ops[i]) begin
      expect_md(ops[i], c_MIN, 32'hFFFF_FFFF);
      run_md(ops[i], c_MIN, 32'hFFFF_FFFF, 1'b0, st, r, tmo);
      e = md_q.pop_front();
      n_tests++;
      if (tmo) begin n_fail++; $display("FAIL ovf_timeout[%0d] got=no_done want=done", i); end
      n_tests++;
      if (r !== e.res) begin n_fail++; $display("FAIL ovf_result[%0d] got=%h want=%h", i, r, e.res); end
      n_tests++;
      if (st !== e.lat) begin n_fail++; $display("FAIL ovf_stall[%0d] got=%0d want=%0d", i, st, e.lat); end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops[4];
    logic [31:0] as[4], bs[4], r;
    md_exp_t e;
    int st;
    bit tmo;
    ops = '{3'd0, 3'd4, 3'd6, 3'd3};
    as  = '{32'd7, 32'd100, -32'sd9, 32'hDEAD_BEEF};
    bs  = '{32'd6, 32'd0, 32'd4, 32'hCAFE_F00D};
    foreach (ops[i]) expect_md(ops[i], as[i], bs[i]);
    foreach (ops[i]) begin
      run_md(ops[i], as[i], bs[i], (i != 3), st, r, tmo);
      e = md_q.pop_front();
      n_tests++;
      if (tmo) begin n_fail++; $display("FAIL b2b_timeout[%0d] got=no_done want=done", i); end
      n_tests++;
      if (r !== e.res) begin n_fail++; $display("FAIL b2b_result[%0d] got=%h want=%h", i, r, e.res); end
      n_tests++;
      if (st !== e.lat) begin n_fail++; $display("FAIL b2b_stall[%0d] got=%0d want=%0d", i, st, e.lat); end
    end
  endtask

  task automatic test_reset_midbusy;
    logic [31:0] r;
    md_exp_t e;
    int st;
    bit tmo;
    bus.MulDivE_i = 1'b1;
    bus.MulDivOpE_i = 3'd0;
    bus.RD1E_i = 32'd5;
    bus.RD2E_i = 32'd6;
    bus.ForwardAE_i = 2'b00;
    bus.ForwardBE_i = 2'b00;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (bus.StallE_o !== 1'b1) begin n_fail++; $display("FAIL midbusy_stall got=%b want=1", bus.StallE_o); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.StallE_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall_async got=%b want=0", bus.StallE_o); end
    bus.MulDivE_i = 1'b0;
    bus.ALUControlE_i = 3'b000;
    bus.ALUSrcE_i = 1'b0;
    bus.RD1E_i = 32'd3;
    bus.RD2E_i = 32'd4;
    #1;
    n_tests++;
    if (bus.ALUResultE_o !== 32'd7) begin
      n_fail++;
      $display("FAIL reset_comb_alu got=%h want=%h", bus.ALUResultE_o, 32'd7);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_md(3'd0, 32'd3, 32'd4);
    run_md(3'd0, 32'd3, 32'd4, 1'b0, st, r, tmo);
    e = md_q.pop_front();
    n_tests++;
    if (tmo) begin n_fail++; $display("FAIL post_reset_timeout got=no_done want=done"); end
    n_tests++;
    if (r !== e.res) begin n_fail++; $display("FAIL post_reset_result got=%h want=%h", r, e.res); end
    n_tests++;
    if (st !== e.lat) begin n_fail++; $display("FAIL post_reset_stall got=%0d want=%0d", st, e.lat); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.ALUControlE_i = '0;
    bus.ALUSrcE_i     = 1'b0;
    bus.BranchE_i     = 1'b0;
    bus.JumpE_i       = 1'b0;
    bus.MulDivE_i     = 1'b0;
    bus.MulDivOpE_i   = '0;
    bus.RD1E_i        = '0;
    bus.RD2E_i        = '0;
    bus.ImmExtE_i     = '0;
    bus.PCE_i         = '0;
    bus.ForwardAE_i   = '0;
    bus.ForwardBE_i   = '0;
    bus.ALUResultM_i  = '0;
    bus.ResultW_i     = '0;
    test_reset();
    test_alu_forward();
    test_branch();
    test_mul();
    test_div();
    test_overflow();
    test_back_to_back();
    test_reset_midbusy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
